clk_tick_rx: RTL

Receiving end of the divided-clock path: takes the slow square wave produced by the system clock divider (e.g. 500 Hz), synchronises it into the CLK_I domain, and emits single-cycle `tick` / `tick_fall` enables for game logic running on CLK_I. It also measures each period in CLK_I cycles and reports lock status and errors, so a stalled or off-frequency divider is detected.

---
 rtl/clk_tick_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/clk_tick_rx.sv
// clk_tick_rx
//   Receives the slow square wave from the system clock divider, synchronises
//   it into the CLK_I domain and produces single-cycle rising/falling edge
//   enables. Each rise-to-rise period is measured in CLK_I cycles and checked
//   against the expected period, giving lock status and error pulses.
//
// Ports
//   CLK_I     in   system clock
//   rst       in   asynchronous active-high reset
//   clk_in    in   slow clock from the divider (asynchronous to CLK_I)
//   tick      out  one-cycle pulse per synchronised rising edge of clk_in
//   tick_fall out  one-cycle pulse per synchronised falling edge of clk_in
//   locked    out  high while LOCK_CNT consecutive good periods have been seen
//   period    out  last measured period in CLK_I cycles
//   err       out  one-cycle pulse on an out-of-tolerance period or a timeout
module clk_tick_rx #(
  parameter int unsigned SYS_CLK  = 100000000,
  parameter int unsigned CLK_IN   = 500,
  parameter int unsigned TOL      = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CW       = 20
) (
  input  logic          CLK_I,
  input  logic          rst,
  input  logic          clk_in,
  output logic          tick,
  output logic          tick_fall,
  output logic          locked,
  output logic [CW-1:0] period,
  output logic          err
);

  localparam int unsigned EXP = SYS_CLK / CLK_IN;
  localparam int unsigned GW  = $clog2(LOCK_CNT + 1);

  localparam logic [CW:0]   P_MIN   = (CW+1)'(EXP - TOL);
  localparam logic [CW:0]   P_MAX   = (CW+1)'(EXP + TOL);
  localparam logic [CW-1:0] CNT_TMO = CW'(EXP + TOL);
  localparam logic [GW:0]   LOCK_V  = (GW+1)'(LOCK_CNT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic          s1, s2, s3;
  logic          rise, fall;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good;
  logic [1:0]    state;
  logic [CW:0]   p_meas;
  logic          p_ok;
  logic [GW:0]   good_inc;
  logic          tmo;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  // One extra bit so cnt+1 cannot wrap when cnt is saturated.
  assign p_meas   = {1'b0, cnt} + (CW+1)'(1);
  assign p_ok     = (p_meas >= P_MIN) && (p_meas <= P_MAX);
  assign good_inc = {1'b0, good} + (GW+1)'(1);
  assign tmo      = (cnt == CNT_TMO);
  // Decoded straight from the state register so lock appears on the same
  // edge as the state change.
  assign locked   = (state == LOCKED);

  always_ff @(posedge CLK_I or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      tick      <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      s1        <= clk_in;
      s2        <= s1;
      s3        <= s2;
      tick      <= rise;
      tick_fall <= fall;
    end
  end

  always_ff @(posedge CLK_I or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The rise branch is tested before the timeout in every state, so a rise
  // landing on the timeout cycle is measured as a period instead.
  always_ff @(posedge CLK_I or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      good   <= '0;
      period <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= ACQ;
            good  <= '0;
          end
        end
        ACQ: begin
          if (rise) begin
            period <= p_meas[CW-1:0];
            if (p_ok) begin
              good <= good_inc[GW-1:0];
              if (good_inc == LOCK_V) begin
                state <= LOCKED;
              end
            end else begin
              good <= '0;
              err  <= 1'b1;
            end
          end else if (tmo) begin
            state <= IDLE;
            good  <= '0;
            err   <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise) begin
            period <= p_meas[CW-1:0];
            if (!p_ok) begin
              state <= ACQ;
              good  <= '0;
              err   <= 1'b1;
            end
          end else if (tmo) begin
            state <= IDLE;
            good  <= '0;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          good  <= '0;
        end
      endcase
    end
  end

endmodule
